// File: rtl/ram_dual_port_param_if.sv
// Two-port RAM bus: per-port access controls and read returns, plus the
// collision status shared by both ports.
interface ram_dual_port_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 16
);
   logic              en_a;
   logic              we_a;
   logic [ADDR_W-1:0] adrs_a;
   logic [DATA_W-1:0] d_a;
   logic [DATA_W-1:0] q_a;
   logic              vld_a;

   logic              en_b;
   logic              we_b;
   logic [ADDR_W-1:0] adrs_b;
   logic [DATA_W-1:0] d_b;
   logic [DATA_W-1:0] q_b;
   logic              vld_b;

   logic              coll;
   logic [CNT_W-1:0]  coll_cnt;

   // Agent side: issues accesses, receives read data and collision status.
   modport master (
      output en_a, we_a, adrs_a, d_a,
      output en_b, we_b, adrs_b, d_b,
      input  q_a, vld_a, q_b, vld_b, coll, coll_cnt
   );

   // RAM side.
   modport slave (
      input  en_a, we_a, adrs_a, d_a,
      input  en_b, we_b, adrs_b, d_b,
      output q_a, vld_a, q_b, vld_b, coll, coll_cnt
   );
endinterface

// File: rtl/ram_dual_port_param.sv
// Parametrised true dual-port synchronous RAM with selectable read-during-write
// behaviour, optional output register, fixed-priority write/write resolution
// and a saturating collision counter. Memory contents are never reset.
module ram_dual_port_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int RD_MODE   = 0,
   parameter int OUT_REG   = 0,
   parameter int COLL_PRIO = 0,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ram_dual_port_param_if.slave  bus
);

   // Depth widened by one bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   // Index 0 is port A, index 1 is port B.
   logic [1:0]             en;
   logic [1:0]             we;
   logic [1:0][ADDR_W-1:0] adrs;
   logic [1:0][DATA_W-1:0] d;
   logic [1:0]             in_rng;
   logic [1:0]             wr;
   logic                   coll_hit;

   logic                   coll_d;
   logic                   coll_q;
   logic [CNT_W-1:0]       coll_cnt_d;
   logic [CNT_W-1:0]       coll_cnt_q;

   logic [DATA_W-1:0]      mem [DEPTH];

   assign en   = {bus.en_b,   bus.en_a};
   assign we   = {bus.we_b,   bus.we_a};
   assign adrs = {bus.adrs_b, bus.adrs_a};
   assign d    = {bus.d_b,    bus.d_a};

   // Same in-range word touched by both ports with at least one writer.
   assign coll_hit = en[0] & en[1] & in_rng[0] & (adrs[0] == adrs[1]) & (we[0] | we[1]);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] rd_data;
         logic [DATA_W-1:0] q1_d;
         logic [DATA_W-1:0] q1_q;
         logic              vld1_d;
         logic              vld1_q;
         logic [DATA_W-1:0] q_out;
         logic              vld_out;

         assign in_rng[gi] = ({1'b0, adrs[gi]} < DEPTH_L);
         // A write loses only when both ports write the same word and the other port has priority.
         assign wr[gi] = en[gi] & we[gi] & in_rng[gi]
                       & ~(coll_hit & we[1-gi] & (COLL_PRIO != gi));

         // Word returned by this access: own data, the other port's data, or the stored word.
         always_comb begin
            rd_data = '0;
            if (in_rng[gi]) begin
               if (we[gi] && RD_MODE == 0)
                  rd_data = d[gi];
               else if (!we[gi] && coll_hit && RD_MODE == 0)
                  rd_data = d[1-gi];
               else
                  rd_data = mem[adrs[gi]];
            end
         end

         // Access stage: capture on enable, otherwise hold; valid strobes per access.
         always_comb begin
            q1_d   = q1_q;
            vld1_d = en[gi];
            if (en[gi])
               q1_d = rd_data;
         end

         // Access-stage registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q1_q   <= '0;
               vld1_q <= 1'b0;
            end else begin
               q1_q   <= q1_d;
               vld1_q <= vld1_d;
            end
         end

         if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] q2_d;
            logic [DATA_W-1:0] q2_q;
            logic              vld2_d;
            logic              vld2_q;

            // Output stage follows the access stage one cycle later, holding between strobes.
            always_comb begin
               q2_d   = vld1_q ? q1_q : q2_q;
               vld2_d = vld1_q;
            end

            // Output-stage registers.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  q2_q   <= '0;
                  vld2_q <= 1'b0;
               end else begin
                  q2_q   <= q2_d;
                  vld2_q <= vld2_d;
               end
            end

            assign q_out   = q2_q;
            assign vld_out = vld2_q;
         end else begin : g_noreg
            assign q_out   = q1_q;
            assign vld_out = vld1_q;
         end
      end
   endgenerate

   // Memory array: both ports write in the same cycle; losing/out-of-range writes are already masked.
   always_ff @(posedge clk) begin
      if (wr[0])
         mem[adrs[0]] <= d[0];
      if (wr[1])
         mem[adrs[1]] <= d[1];
   end

   // Collision pulse and saturating count.
   always_comb begin
      coll_d     = coll_hit;
      coll_cnt_d = coll_cnt_q;
      if (coll_hit && coll_cnt_q != {CNT_W{1'b1}})
         coll_cnt_d = coll_cnt_q + CNT_W'(1);
   end

   // Collision status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_q     <= 1'b0;
         coll_cnt_q <= '0;
      end else begin
         coll_q     <= coll_d;
         coll_cnt_q <= coll_cnt_d;
      end
   end

   assign bus.q_a      = g_port[0].q_out;
   assign bus.vld_a    = g_port[0].vld_out;
   assign bus.q_b      = g_port[1].q_out;
   assign bus.vld_b    = g_port[1].vld_out;
   assign bus.coll     = coll_q;
   assign bus.coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_ram_dual_port_param.sv
// Directed bench for two RAM configurations driven with identical stimulus:
//   dut0: DEPTH=48, write-first, no output reg, A wins, 2-bit counter
//   dut1: DEPTH=64, read-first, output reg,   B wins, 16-bit counter
// Expected returns are queued when an access is issued and compared when due.
module tb_ram_dual_port_param;

   logic clk;
   logic rst_n;

   logic       en_a, we_a, en_b, we_b;
   logic [5:0] adrs_a, adrs_b;
   logic [7:0] d_a, d_b;

   ram_dual_port_param_if #(.DATA_W(8), .ADDR_W(6), .CNT_W(2))  if0 ();
   ram_dual_port_param_if #(.DATA_W(8), .ADDR_W(6), .CNT_W(16)) if1 ();

   assign if0.en_a = en_a;   assign if1.en_a = en_a;
   assign if0.we_a = we_a;   assign if1.we_a = we_a;
   assign if0.adrs_a = adrs_a; assign if1.adrs_a = adrs_a;
   assign if0.d_a = d_a;     assign if1.d_a = d_a;
   assign if0.en_b = en_b;   assign if1.en_b = en_b;
   assign if0.we_b = we_b;   assign if1.we_b = we_b;
   assign if0.adrs_b = adrs_b; assign if1.adrs_b = adrs_b;
   assign if0.d_b = d_b;     assign if1.d_b = d_b;

   ram_dual_port_param #(
      .DATA_W(8), .ADDR_W(6), .DEPTH(48), .RD_MODE(0),
      .OUT_REG(0), .COLL_PRIO(0), .CNT_W(2)
   ) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );

   ram_dual_port_param #(
      .DATA_W(8), .ADDR_W(6), .DEPTH(64), .RD_MODE(1),
      .OUT_REG(1), .COLL_PRIO(1), .CNT_W(16)
   ) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      int         dut;
      int         port;   // 0 = A, 1 = B, 2 = coll
      logic       vld;
      logic [7:0] q;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic get_obs(input int dut, input int port, output logic v, output logic [7:0] q);
      v = 1'b0;
      q = '0;
      if (dut == 0) begin
         case (port)
            0: begin v = if0.vld_a; q = if0.q_a; end
            1: begin v = if0.vld_b; q = if0.q_b; end
            default: v = if0.coll;
         endcase
      end else begin
         case (port)
            0: begin v = if1.vld_a; q = if1.q_a; end
            1: begin v = if1.vld_b; q = if1.q_b; end
            default: v = if1.coll;
         endcase
      end
   endtask

   // One clock of traffic; qa0/qb0 expected from dut0, qa1/qb1 from dut1 (x = not checked).
   task automatic cyc_go(input logic ea, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                         input logic eb, input logic wb, input logic [5:0] ab, input logic [7:0] db,
                         input logic [7:0] qa0, input logic [7:0] qb0,
                         input logic [7:0] qa1, input logic [7:0] qb1,
                         input logic c, input string tag);
      exp_t e;
      logic       ov;
      logic [7:0] oq;
      en_a = ea; we_a = wa; adrs_a = aa; d_a = da;
      en_b = eb; we_b = wb; adrs_b = ab; d_b = db;
      sb.push_back('{cyc + 1, 0, 0, ea, qa0, tag});
      sb.push_back('{cyc + 1, 0, 1, eb, qb0, tag});
      sb.push_back('{cyc + 1, 0, 2, c,  8'h00, tag});
      sb.push_back('{cyc + 2, 1, 0, ea, qa1, tag});
      sb.push_back('{cyc + 2, 1, 1, eb, qb1, tag});
      sb.push_back('{cyc + 1, 1, 2, c,  8'h00, tag});
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            e = sb[i];
            sb.delete(i);
            get_obs(e.dut, e.port, ov, oq);
            if (e.port == 2) begin
               chk($sformatf("%s/d%0d/coll", e.tag, e.dut), {31'd0, ov}, {31'd0, e.vld});
            end else begin
               chk($sformatf("%s/d%0d/vld_%s", e.tag, e.dut, e.port == 0 ? "a" : "b"),
                   {31'd0, ov}, {31'd0, e.vld});
               if (e.vld && !$isunknown(e.q))
                  chk($sformatf("%s/d%0d/q_%s", e.tag, e.dut, e.port == 0 ? "a" : "b"),
                      {24'd0, oq}, {24'd0, e.q});
            end
         end
      end
      $display("cyc %0d %s: A en=%0b we=%0b ad=%0d d=%h  B en=%0b we=%0b ad=%0d d=%h",
               cyc, tag, ea, wa, aa, da, eb, wb, ab, db);
   endtask

   task automatic idle(input string tag);
      cyc_go(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 8'hxx, 8'hxx, 8'hxx, 8'hxx, 1'b0, tag);
   endtask

   localparam logic [7:0] X = 8'hxx;

   initial begin
      rst_n = 1'b0;
      en_a = 0; we_a = 0; adrs_a = '0; d_a = '0;
      en_b = 0; we_b = 0; adrs_b = '0; d_b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst/d0/q_a", {24'd0, if0.q_a}, 32'h0);
      chk("rst/d1/q_b", {24'd0, if1.q_b}, 32'h0);
      chk("rst/d0/vld", {30'd0, if0.vld_a, if0.vld_b}, 32'h0);
      chk("rst/d1/vld", {30'd0, if1.vld_a, if1.vld_b}, 32'h0);
      chk("rst/d0/cnt", {30'd0, if0.coll_cnt}, 32'h0);
      chk("rst/d1/cnt", {16'd0, if1.coll_cnt}, 32'h0);

      //     A: en we adr  d      B: en we adr  d      q: a0     b0     a1     b1    coll
      cyc_go(1, 1, 6'd5,  8'hA5, 0, 0, 6'd0,  8'h00, 8'hA5, X,     X,     X,     1'b0, "wr5");
      cyc_go(0, 0, 6'd0,  8'h00, 1, 0, 6'd5,  8'h00, X,     8'hA5, X,     8'hA5, 1'b0, "rd5");
      cyc_go(1, 1, 6'd3,  8'h11, 0, 0, 6'd0,  8'h00, 8'h11, X,     X,     X,     1'b0, "wr3a");
      cyc_go(1, 1, 6'd3,  8'h22, 0, 0, 6'd0,  8'h00, 8'h22, X,     8'h11, X,     1'b0, "rdw3");
      cyc_go(1, 0, 6'd3,  8'h00, 0, 0, 6'd0,  8'h00, 8'h22, X,     8'h22, X,     1'b0, "rd3");
      cyc_go(1, 1, 6'd9,  8'h0F, 1, 1, 6'd9,  8'hF0, 8'h0F, 8'hF0, X,     X,     1'b1, "ww9");
      chk("ww9/d0/cnt", {30'd0, if0.coll_cnt}, 32'd1);
      chk("ww9/d1/cnt", {16'd0, if1.coll_cnt}, 32'd1);
      cyc_go(1, 0, 6'd9,  8'h00, 0, 0, 6'd0,  8'h00, 8'h0F, X,     8'hF0, X,     1'b0, "rd9");
      cyc_go(1, 1, 6'd7,  8'h33, 0, 0, 6'd0,  8'h00, 8'h33, X,     X,     X,     1'b0, "wr7");
      cyc_go(1, 0, 6'd7,  8'h00, 1, 1, 6'd7,  8'h44, 8'h44, 8'h44, 8'h33, 8'h33, 1'b1, "rw7");
      cyc_go(1, 0, 6'd7,  8'h00, 1, 0, 6'd7,  8'h00, 8'h44, 8'h44, 8'h44, 8'h44, 1'b0, "rr7");
      chk("rr7/d0/cnt", {30'd0, if0.coll_cnt}, 32'd2);
      chk("rr7/d1/cnt", {16'd0, if1.coll_cnt}, 32'd2);
      cyc_go(1, 1, 6'd50, 8'h77, 0, 0, 6'd0,  8'h00, 8'h00, X,     X,     X,     1'b0, "wr50");
      cyc_go(1, 0, 6'd50, 8'h00, 0, 0, 6'd0,  8'h00, 8'h00, X,     8'h77, X,     1'b0, "rd50");
      cyc_go(1, 1, 6'd10, 8'h01, 1, 1, 6'd10, 8'h81, 8'h01, 8'h81, X,     X,     1'b1, "ww10a");
      cyc_go(1, 1, 6'd10, 8'h02, 1, 1, 6'd10, 8'h82, 8'h02, 8'h82, 8'h81, 8'h81, 1'b1, "ww10b");
      cyc_go(1, 1, 6'd10, 8'h03, 1, 1, 6'd10, 8'h83, 8'h03, 8'h83, 8'h82, 8'h82, 1'b1, "ww10c");
      chk("sat/d0/cnt", {30'd0, if0.coll_cnt}, 32'd3);
      chk("sat/d1/cnt", {16'd0, if1.coll_cnt}, 32'd5);

      // Reset mid-traffic: dut0 output and dut1 pipeline hold a live read of addr 3.
      cyc_go(1, 0, 6'd3,  8'h00, 0, 0, 6'd0,  8'h00, 8'h22, X,     8'h22, X,     1'b0, "rd3b");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst/d0/q_a", {24'd0, if0.q_a}, 32'h0);
      chk("arst/d0/vld", {30'd0, if0.vld_a, if0.vld_b}, 32'h0);
      chk("arst/d1/vld", {30'd0, if1.vld_a, if1.vld_b}, 32'h0);
      chk("arst/d0/cnt", {30'd0, if0.coll_cnt}, 32'h0);
      chk("arst/d1/cnt", {16'd0, if1.coll_cnt}, 32'h0);
      sb.delete();
      en_a = 0; en_b = 0; we_a = 0; we_b = 0;
      @(posedge clk);
      #1;
      cyc++;
      chk("arst/d1/q_a", {24'd0, if1.q_a}, 32'h0);
      rst_n = 1'b1;

      cyc_go(1, 0, 6'd3,  8'h00, 1, 0, 6'd5,  8'h00, 8'h22, 8'hA5, 8'h22, 8'hA5, 1'b0, "post");
      cyc_go(1, 1, 6'd20, 8'h55, 1, 1, 6'd21, 8'h66, 8'h55, 8'h66, X,     X,     1'b0, "wwdiff");
      cyc_go(1, 0, 6'd21, 8'h00, 1, 0, 6'd20, 8'h00, 8'h66, 8'h55, 8'h66, 8'h55, 1'b0, "rrdiff");
      idle("idle1");
      idle("idle2");
      chk("end/d0/cnt", {30'd0, if0.coll_cnt}, 32'h0);
      chk("end/d1/cnt", {16'd0, if1.coll_cnt}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
